// File: rtl/vector_dot_stream_ctrl_if.sv
// vector_dot_stream_ctrl_if: job control, operand stream and result handshake bundle
interface vector_dot_stream_ctrl_if #(
  parameter int element_width = 32,
  parameter int no_of_units = 8
);
  logic start;
  logic [31:0] total;
  logic [element_width*no_of_units-1:0] first_row_plus_additional;
  logic [element_width*no_of_units-1:0] vector2;
  logic in_valid;
  logic in_ready;
  logic [element_width-1:0] dot_product_output;
  logic out_valid;
  logic out_ready;
  logic finish;
  logic busy;
  logic overflow;
  modport master(
    output start, total, first_row_plus_additional, vector2, in_valid, out_ready,
    input in_ready, dot_product_output, out_valid, finish, busy, overflow
  );
  modport slave(
    input start, total, first_row_plus_additional, vector2, in_valid, out_ready,
    output in_ready, dot_product_output, out_valid, finish, busy, overflow
  );
endinterface

// File: rtl/vector_dot_stream_ctrl.sv
// vector_dot_stream_ctrl: chunked dot product with lane masking, 3-stage pipeline and saturated result
module vector_dot_stream_ctrl #(
  parameter int element_width = 32,
  parameter int no_of_units = 8,
  parameter int frac_bits = 0,
  parameter int acc_width = 2*element_width+16
)(
  input logic clk,
  input logic reset,
  vector_dot_stream_ctrl_if.slave bus
);
  localparam logic signed [acc_width-1:0] smax = {{(acc_width-element_width+1){1'b0}}, {(element_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] smin = {{(acc_width-element_width+1){1'b1}}, {(element_width-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] tot, base;
  logic signed [2*element_width-1:0] prod [no_of_units];
  logic signed [2*element_width-1:0] s1 [no_of_units];
  logic s1_v, s2_v, finish, overflow, accept, last, drained, hi, lo;
  logic signed [acc_width-1:0] s2, acc, sum, shifted;
  logic [element_width-1:0] result;
  assign accept = bus.in_valid && state == LOAD;
  assign last = {1'b0, base} + 33'(no_of_units) >= {1'b0, tot};
  assign drained = state == DRAIN && !s1_v && !s2_v;
  assign shifted = acc >>> frac_bits;
  assign hi = shifted > smax;
  assign lo = shifted < smin;
  assign bus.in_ready = state == LOAD;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.dot_product_output = result;
  assign bus.finish = finish;
  assign bus.overflow = overflow;
  // full-width signed lane products and their sum
  always_comb begin
    sum = '0;
    for (int i = 0; i < no_of_units; i++) begin
      prod[i] = $signed(bus.first_row_plus_additional[i*element_width +: element_width]) *
                $signed(bus.vector2[i*element_width +: element_width]);
      sum = sum + acc_width'(s1[i]);
    end
  end
  // next state
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (bus.start ? (bus.total == 0 ? DONE : LOAD) : IDLE) :
              state == LOAD  ? (accept && last ? DRAIN : LOAD) :
              state == DRAIN ? (drained ? DONE : DRAIN) :
                               (bus.out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // stage 1 product capture; dead lanes beyond total contribute zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < no_of_units; i++)
      if (accept) s1[i] <= ({1'b0, base} + 33'(i)) < {1'b0, tot} ? prod[i] : '0;
  end
  // valid bits, tree sum, accumulator, job bookkeeping and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s2 <= '0;
      acc <= '0;
      tot <= '0;
      base <= '0;
      result <= '0;
      overflow <= 1'b0;
      finish <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      s2 <= sum;
      finish <= state_n == DONE && state != DONE;
      if (accept) base <= base + 32'(no_of_units);
      if (state == IDLE && bus.start) begin
        tot <= bus.total;
        base <= '0;
        acc <= '0;
        overflow <= 1'b0;
        if (bus.total == 0) result <= '0;
      end else if (s2_v) acc <= acc + s2;
      if (drained) begin
        result <= hi ? smax[element_width-1:0] : lo ? smin[element_width-1:0] : shifted[element_width-1:0];
        overflow <= hi || lo;
      end
    end
  end
endmodule

// File: tb/tb_vector_dot_stream_ctrl.sv
// tb_vector_dot_stream_ctrl: randomized jobs checked against an element-wise dot product model
module tb_vector_dot_stream_ctrl;
  localparam int W = 32;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total_n = 0;
  int bad_n = 0;
  int cyc = 0;
  int a [64];
  int b [64];
  vector_dot_stream_ctrl_if #(.element_width(W), .no_of_units(N)) bus();
  vector_dot_stream_ctrl #(.element_width(W), .no_of_units(N), .frac_bits(0), .acc_width(2*W+16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model(input int t, output logic [31:0] r, output logic o);
    logic signed [95:0] s;
    s = '0;
    for (int k = 0; k < t; k++) s = s + 96'(a[k]) * 96'(b[k]);
    o = s > 96'sh7FFFFFFF || s < -96'sh80000000;
    r = s > 96'sh7FFFFFFF ? 32'h7FFFFFFF : s < -96'sh80000000 ? 32'h80000000 : s[31:0];
  endtask
  task automatic fill_const(input int t, input int av, input int bv, input int dead);
    for (int k = 0; k < 64; k++) begin
      a[k] = k < t ? av : dead;
      b[k] = k < t ? bv : dead;
    end
  endtask
  task automatic fill_rand;
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(1) == 1) begin
        a[k] = $urandom;
        b[k] = $urandom;
      end else begin
        a[k] = $urandom_range(200) - 100;
        b[k] = $urandom_range(200) - 100;
      end
    end
  endtask
  task automatic drive_beat(input int bi);
    for (int i = 0; i < N; i++) begin
      bus.first_row_plus_additional[i*W +: W] = a[bi*N+i];
      bus.vector2[i*W +: W] = b[bi*N+i];
    end
    bus.in_valid = 1'b1;
  endtask
  task automatic run_job(input int t, input int gap, input int hold, input bit start_in_done);
    logic [31:0] er;
    logic eo;
    int nb, s, gaps, n, g;
    model(t, er, eo);
    nb = (t + N - 1) / N;
    gaps = 0;
    bus.start = 1'b1;
    bus.total = t;
    tick;
    bus.start = 1'b0;
    bus.total = $urandom;
    s = cyc;
    if (t > 0) check("in_ready_after_start", {63'd0, bus.in_ready}, 64'd1);
    check("busy_after_start", {63'd0, bus.busy}, 64'd1);
    for (int bi = 0; bi < nb; bi++) begin
      g = gap < 0 ? $urandom_range(2) : (bi > 0 ? gap : 0);
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.first_row_plus_additional = {N{$urandom}};
        bus.vector2 = {N{$urandom}};
        tick;
      end
      gaps += g;
      drive_beat(bi);
      tick;
      bus.in_valid = 1'b0;
    end
    if (t > 0) check("in_ready_after_last", {63'd0, bus.in_ready}, 64'd0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick;
      n++;
    end
    check("latency", 64'(cyc - s), t == 0 ? 64'd0 : 64'(nb + gaps + 3));
    check("finish_first", {63'd0, bus.finish}, 64'd1);
    check("result", {32'd0, bus.dot_product_output}, {32'd0, er});
    check("overflow", {63'd0, bus.overflow}, {63'd0, eo});
    repeat (hold) begin
      if (start_in_done) begin
        bus.start = 1'b1;
        bus.total = 8;
      end
      tick;
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_result", {32'd0, bus.dot_product_output}, {32'd0, er});
      check("finish_once", {63'd0, bus.finish}, 64'd0);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check("out_valid_fall", {63'd0, bus.out_valid}, 64'd0);
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.total = '0;
    bus.first_row_plus_additional = '0;
    bus.vector2 = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_finish", {63'd0, bus.finish}, 64'd0);
    check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
    check("rst_result", {32'd0, bus.dot_product_output}, 64'd0);
    reset = 1'b0;
    tick;
    fill_const(8, 1, 3, 0);
    run_job(8, 0, 0, 1'b0);
    fill_const(5, 2, 5, 32'h7FFFFFFF);
    run_job(5, 0, 0, 1'b0);
    fill_const(20, 1, 1, 32'h7FFFFFFF);
    run_job(20, 2, 0, 1'b0);
    fill_const(8, 1, 3, 0);
    run_job(8, 0, 10, 1'b1);
    fill_const(8, 32'h40000000, 32'h40000000, 0);
    run_job(8, 0, 1, 1'b0);
    fill_const(5, 2, 5, 32'h7FFFFFFF);
    run_job(5, 0, 0, 1'b0);
    run_job(0, 0, 2, 1'b0);
    fill_const(20, 7, 9, 32'h7FFFFFFF);
    bus.start = 1'b1;
    bus.total = 20;
    tick;
    bus.start = 1'b0;
    drive_beat(0);
    tick;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    fill_const(8, 3, -4, 5);
    run_job(8, 0, 0, 1'b0);
    for (int j = 0; j < 14; j++) begin
      fill_rand;
      run_job($urandom_range(40), -1, $urandom_range(3), 1'($urandom_range(1)));
    end
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule

// File: doc/vector_dot_stream_ctrl.md
# vector_dot_stream_ctrl

Parametrised, handshaked dot-product engine for the CG datapath. It accepts two vectors as a stream of `no_of_units`-lane chunks and masks the partial last chunk when `total` is not a multiple of `no_of_units`. Lane products are summed through a fixed-latency pipeline and accumulated. The block returns one saturated fixed-point result per `start`, held until the consumer accepts it.

## Interface
- `element_width`, 32: signed two's-complement element and result width.
- `no_of_units`, 8: lanes per chunk; power of two, ≥1.
- `frac_bits`, 0: fixed-point fraction bits. The result is the accumulator arithmetically shifted right by `frac_bits`.
- `acc_width`, 2*element_width+16: internal accumulator width.
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a job when IDLE; ignored in every other state.
- `total`  in  32  element count, latched when `start` is accepted.
- `first_row_plus_additional`  in  element_width*no_of_units  operand A chunk; lane i is bits [i*element_width +: element_width].
- `vector2`  in  element_width*no_of_units  operand B chunk, same lane layout as operand A.
- `in_valid`  in  1  the chunk on both operand buses is valid.
- `in_ready`  out  1  high only in LOAD.
- `dot_product_output`  out  element_width  saturated result.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `finish`  out  1  one-cycle pulse in the first cycle of DONE.
- `busy`  out  1  high whenever the state is not IDLE.
- `overflow`  out  1  sticky; set when the result saturated. Cleared by `start` or `reset`.

## Operation
- **Reset values:** state IDLE; all outputs 0; accumulator and both pipeline valid bits 0.
- **IDLE:**
  - `start` with `total`>0 latches `total`, clears the accumulator, clears `overflow`, sets beat index b=0, and moves to LOAD.
  - `start` with `total`=0 loads result 0 and moves directly to DONE.
- **LOAD:**
  - A beat is accepted on each edge with `in_valid`&`in_ready`.
  - Lane i of beat b is live when b*no_of_units+i < `total`. Dead lanes contribute 0 whatever their data.
  - After beat ceil(`total`/no_of_units)-1 is accepted, the state moves to DRAIN. `in_ready` drops the same edge.
- **Pipeline:**
  - Stage 1 registers the full-width signed lane products of the accepted beat.
  - Stage 2 registers the adder-tree sum of stage 1.
  - Stage 3 adds stage 2 into the accumulator.
  - Each stage carries its own valid bit. `in_valid` bubbles advance the pipeline without accumulating anything.
- **DRAIN:** when both stage valid bits are clear, the output register loads sat(acc >>> frac_bits) and the state moves to DONE.
- **DONE:**
  - `out_valid`=1; `dot_product_output` is held stable.
  - On `out_ready`=1 the state returns to IDLE and `out_valid` falls on that edge.
- **Saturation:** a shifted value above 2^(element_width-1)-1 or below -2^(element_width-1) clamps to that bound and sets `overflow`.
- **Reset mid-operation:** any state returns to IDLE next edge. Pipeline contents are discarded and no result is produced.
- **Ignored inputs:** `start` is ignored outside IDLE. Operand inputs are ignored outside LOAD.

## Timing
- **Start:** `start` accepted at edge S → `in_ready` high from after S.
- **Result latency:**
  - Last beat accepted at edge E: stage 1 updates at E, stage 2 at E+1, accumulator at E+2.
  - The output register loads, `out_valid` rises and `finish` pulses after E+3.
  - With a single chunk and no bubbles, `out_valid` rises after S+4.
- **Throughput:** one chunk per cycle while `in_valid` is held high. A back-to-back job can start the edge after the output handshake.
- **`total`=0:** `out_valid` rises after S, and `finish` pulses in that cycle.

## Test plan
- no_of_units=8, `total`=8, all lanes A=1 and B=3 → result 24, `overflow`=0; `out_valid` first high 4 cycles after `start`.
- `total`=5; lanes 5..7 carry A=B=0x7FFFFFFF; live lanes A=2, B=5 → result 50, confirming dead lanes are masked.
- `total`=20, three chunks with `in_valid` low for 2 cycles between beats; each lane product is 1 → result 20. `in_ready` must drop after the third accepted beat.
- `out_ready` held low for 10 cycles in DONE → `out_valid` stays high, result unchanged, `finish` pulses exactly once. A `start` pulse during DONE is ignored.
- `total`=8, every lane A=B=0x40000000, `frac_bits`=0 → result 0x7FFFFFFF, `overflow`=1. A following job with a small result clears `overflow`.
- `reset` asserted mid-LOAD after 1 of 3 beats → next cycle `busy`=0, `in_ready`=0, `out_valid`=0. A new `total`=8 job then returns the correct value, with no residue from the aborted job.
